// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one main-memory port between an instruction-cache line-fill port and
// a data-cache fill/writeback port. One transaction is in flight at a time.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Every output
// is a flop, loaded from the next-value logic in the combinational process.
//
// Parameters
//   ADDR_W     byte address width
//   LINE_BITS  cache-line width in bits
//   TIMEOUT    number of WAIT cycles before the transaction ends with an error
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   ic_req/ic_addr     icache fill request, held until ic_ack or ic_kill
//   ic_kill            branch flush; cancels the icache request
//   ic_ack             one-cycle icache completion pulse
//   dc_req/dc_we       dcache request (dc_we=1 writeback, 0 fill)
//   dc_addr/dc_wdata   dcache address and writeback line
//   dc_ack             one-cycle dcache completion pulse
//   rsp_data/rsp_err   returned line and timeout flag, valid with an ack
//   mem_req/mem_we     one-cycle memory request strobe and write flag
//   mem_addr/mem_wdata line-aligned memory address and write line
//   mem_rvalid/rdata   memory completion and read line
//   busy               high whenever the arbiter is not in IDLE
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int LINE_BITS = 128,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [ADDR_W-1:0]    ic_addr,
  input  logic                 ic_kill,
  output logic                 ic_ack,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_W-1:0]    dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_ack,
  output logic [LINE_BITS-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [LINE_BITS-1:0] mem_rdata,
  output logic                 busy
);

  localparam int OFS   = $clog2(LINE_BITS / 8);
  localparam int CNT_W = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFS){1'b1}}, {OFS{1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

  // Registered state
  state_t               state;
  logic                 owner;
  logic                 last_owner;
  logic                 kill_pending;
  logic [CNT_W-1:0]     cnt;

  // Next values
  state_t               state_nx;
  logic                 owner_nx;
  logic                 last_owner_nx;
  logic                 kill_pending_nx;
  logic [CNT_W-1:0]     cnt_nx;
  logic                 ic_ack_nx;
  logic                 dc_ack_nx;
  logic [LINE_BITS-1:0] rsp_data_nx;
  logic                 rsp_err_nx;
  logic                 mem_req_nx;
  logic                 mem_we_nx;
  logic [ADDR_W-1:0]    mem_addr_nx;
  logic [LINE_BITS-1:0] mem_wdata_nx;
  logic                 busy_nx;

  // Arbitration helpers
  logic ic_elig;
  logic grant_dc;
  logic kill_now;
  logic deliver;

  assign ic_elig = ic_req & ~ic_kill;
  // DC wins when it is the only eligible requester, or on contention when
  // IC was served last.
  assign grant_dc = dc_req & (~ic_elig | (last_owner == OWN_IC));

  // A kill seen in the same cycle the transaction leaves WAIT must already
  // suppress the ack, so the live ic_kill is folded in with kill_pending.
  assign kill_now = kill_pending | ((owner == OWN_IC) & ic_kill);
  assign deliver  = (owner == OWN_DC) | ~kill_now;

  always_comb begin
    state_nx        = state;
    owner_nx        = owner;
    last_owner_nx   = last_owner;
    kill_pending_nx = kill_pending;
    cnt_nx          = cnt;
    ic_ack_nx       = 1'b0;
    dc_ack_nx       = 1'b0;
    rsp_data_nx     = rsp_data;
    rsp_err_nx      = 1'b0;
    mem_req_nx      = 1'b0;
    mem_we_nx       = 1'b0;
    mem_addr_nx     = mem_addr;
    mem_wdata_nx    = mem_wdata;

    unique case (state)
      IDLE: begin
        kill_pending_nx = 1'b0;
        if (ic_elig || dc_req) begin
          state_nx   = ISSUE;
          owner_nx   = grant_dc ? OWN_DC : OWN_IC;
          mem_req_nx = 1'b1;
          if (grant_dc) begin
            mem_we_nx    = dc_we;
            mem_addr_nx  = line_align(dc_addr);
            mem_wdata_nx = dc_wdata;
          end else begin
            mem_we_nx    = 1'b0;
            mem_addr_nx  = line_align(ic_addr);
            mem_wdata_nx = '0;
          end
        end
      end

      ISSUE: begin
        state_nx = WAIT;
        cnt_nx   = '0;
        if ((owner == OWN_IC) && ic_kill) begin
          kill_pending_nx = 1'b1;
        end
      end

      WAIT: begin
        kill_pending_nx = kill_now;
        if (mem_rvalid || (cnt == CNT_LAST)) begin
          state_nx = RESP;
          // A killed icache transaction still drains the memory side but
          // neither acks nor disturbs the held response data.
          if (deliver) begin
            ic_ack_nx   = (owner == OWN_IC);
            dc_ack_nx   = (owner == OWN_DC);
            rsp_err_nx  = ~mem_rvalid;
            rsp_data_nx = mem_rvalid ? mem_rdata : '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end

      RESP: begin
        state_nx      = IDLE;
        last_owner_nx = owner;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= OWN_IC;
      last_owner   <= OWN_IC;
      kill_pending <= 1'b0;
      cnt          <= '0;
      ic_ack       <= 1'b0;
      dc_ack       <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      owner        <= owner_nx;
      last_owner   <= last_owner_nx;
      kill_pending <= kill_pending_nx;
      cnt          <= cnt_nx;
      ic_ack       <= ic_ack_nx;
      dc_ack       <= dc_ack_nx;
      rsp_data     <= rsp_data_nx;
      rsp_err      <= rsp_err_nx;
      mem_req      <= mem_req_nx;
      mem_we       <= mem_we_nx;
      mem_addr     <= mem_addr_nx;
      mem_wdata    <= mem_wdata_nx;
      busy         <= busy_nx;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Directed bench for mem_bus_arbiter (TIMEOUT=8). Stimulus pushes the
// expected memory requests and expected acks into queues; a monitor pops and
// compares whenever mem_req or an ack appears. A small memory model answers
// each mem_req after mem_delay cycles.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int LB = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, ic_kill, ic_ack;
  logic [AW-1:0] ic_addr;
  logic          dc_req, dc_we, dc_ack;
  logic [AW-1:0] dc_addr;
  logic [LB-1:0] dc_wdata;
  logic [LB-1:0] rsp_data;
  logic          rsp_err;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [LB-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [LB-1:0] mem_rdata;
  logic          busy;

  mem_bus_arbiter #(.ADDR_W(AW), .LINE_BITS(LB), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_kill(ic_kill), .ic_ack(ic_ack),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ack(dc_ack), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic dc; logic [LB-1:0] data; logic err; } rsp_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [LB-1:0] wdata; } mreq_t;

  rsp_t  rq[$];
  mreq_t mq[$];

  int errors = 0;
  int checks = 0;

  int          mem_delay = 1;
  logic        use_fixed = 1'b0;
  logic [LB-1:0] fixed_line = '0;

  function automatic logic [LB-1:0] pat(input logic [AW-1:0] a);
    return {4{32'hC0DE_0000 ^ a}};
  endfunction

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_m(input logic we, input logic [AW-1:0] a, input logic [LB-1:0] wd);
    mreq_t m;
    m.we = we; m.addr = a; m.wdata = wd;
    mq.push_back(m);
  endtask

  task automatic push_r(input logic dc, input logic [LB-1:0] d, input logic err);
    rsp_t r;
    r.dc = dc; r.data = d; r.err = err;
    rq.push_back(r);
  endtask

  task automatic wait_ack(input logic want_dc, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_dc ? dc_ack : ic_ack) && n < max_cyc);
    if (!(want_dc ? dc_ack : ic_ack)) begin
      checks++; errors++;
      $display("FAIL ack_wait: got no ack after %0d cycles want ack", max_cyc);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy=1 after %0d cycles want 0", max_cyc);
    end
    @(negedge clk);
  endtask

  // Memory model: answers each mem_req mem_delay cycles later.
  initial begin
    logic [LB-1:0] d;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        d = use_fixed ? fixed_line : pat(mem_addr);
        repeat (mem_delay) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    rsp_t  r;
    mreq_t m;
    forever begin
      @(negedge clk);
      if (ic_ack || dc_ack) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got ic_ack=%b dc_ack=%b want none", ic_ack, dc_ack);
        end else begin
          r = rq.pop_front();
          chk("ack_owner", {ic_ack, dc_ack}, r.dc ? 2'b01 : 2'b10);
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_err", rsp_err, r.err);
        end
      end else begin
        chk("rsp_err_idle", rsp_err, 1'b0);
      end
      if (mem_req) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req: got addr=%h want none", mem_addr);
        end else begin
          m = mq.pop_front();
          chk("mem_we", mem_we, m.we);
          chk("mem_addr", mem_addr, m.addr);
          chk("mem_wdata", mem_wdata, m.wdata);
        end
      end
    end
  end

  initial begin
    logic [LB-1:0] wb;
    int ic_n, dc_n, guard;
    wb = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    rst = 1'b0;
    ic_req = 1'b0; ic_kill = 1'b0; ic_addr = '0;
    dc_req = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;

    // Reset values before any clock edge
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_ic_ack", ic_ack, 1'b0);
    chk("rst_dc_ack", dc_ack, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rsp_data", rsp_data, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Contention from reset: DC, IC, DC, IC
    ic_req = 1'b1; ic_addr = 32'h0000_010C;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0200;
    push_m(1'b0, 32'h200, '0); push_r(1'b1, pat(32'h200), 1'b0);
    push_m(1'b0, 32'h100, '0); push_r(1'b0, pat(32'h100), 1'b0);
    push_m(1'b0, 32'h300, '0); push_r(1'b1, pat(32'h300), 1'b0);
    push_m(1'b0, 32'h140, '0); push_r(1'b0, pat(32'h140), 1'b0);
    ic_n = 0; dc_n = 0; guard = 0;
    while ((ic_n < 2 || dc_n < 2) && guard < 100) begin
      @(negedge clk);
      guard++;
      if (dc_ack) begin
        dc_n++;
        if (dc_n == 2) dc_req = 1'b0; else dc_addr = 32'h0000_0300;
      end
      if (ic_ack) begin
        ic_n++;
        if (ic_n == 2) ic_req = 1'b0; else ic_addr = 32'h0000_014F;
      end
    end
    if (guard >= 100) begin
      checks++; errors++;
      $display("FAIL contention_wait: got ic=%0d dc=%0d acks want 2 each", ic_n, dc_n);
    end
    wait_idle(20);

    // Minimum latency dcache fill, memory answers one cycle after mem_req
    mem_delay = 1;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_2345;
    push_m(1'b0, 32'h2340, '0); push_r(1'b1, pat(32'h2340), 1'b0);
    @(negedge clk);
    chk("lat_issue_busy", busy, 1'b1);
    @(negedge clk);
    chk("lat_wait_ack", dc_ack, 1'b0);
    @(negedge clk);
    chk("lat_resp_ack", dc_ack, 1'b1);
    dc_req = 1'b0;
    @(negedge clk);
    chk("lat_idle_busy", busy, 1'b0);
    chk("rsp_data_hold", rsp_data, pat(32'h2340));

    // Icache fill, memory returns A5 pattern two cycles after mem_req
    use_fixed = 1'b1; fixed_line = {16{8'hA5}}; mem_delay = 2;
    ic_req = 1'b1; ic_addr = 32'h0000_1234;
    push_m(1'b0, 32'h1230, '0); push_r(1'b0, {16{8'hA5}}, 1'b0);
    wait_ack(1'b0, 20);
    ic_req = 1'b0;
    wait_idle(20);
    use_fixed = 1'b0;

    // Writeback
    mem_delay = 1;
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_4008; dc_wdata = wb;
    push_m(1'b1, 32'h4000, wb); push_r(1'b1, pat(32'h4000), 1'b0);
    wait_ack(1'b1, 20);
    dc_req = 1'b0; dc_we = 1'b0; dc_wdata = '0;
    wait_idle(20);

    // Kill during WAIT, dcache request pending meanwhile
    mem_delay = 4;
    ic_req = 1'b1; ic_addr = 32'h0000_0800;
    push_m(1'b0, 32'h800, '0);
    @(negedge clk);
    @(negedge clk);
    ic_kill = 1'b1; ic_req = 1'b0;
    dc_req = 1'b1; dc_addr = 32'h0000_0900;
    push_m(1'b0, 32'h900, '0); push_r(1'b1, pat(32'h900), 1'b0);
    @(negedge clk);
    ic_kill = 1'b0;
    repeat (3) @(negedge clk);
    chk("kill_resp_busy", busy, 1'b1);
    chk("kill_no_ic_ack", ic_ack, 1'b0);
    @(negedge clk);
    chk("kill_idle_busy", busy, 1'b0);
    wait_ack(1'b1, 20);
    dc_req = 1'b0;
    wait_idle(20);

    // Timeout: memory answers only after the arbiter has given up
    mem_delay = 12;
    dc_req = 1'b1; dc_addr = 32'h0000_0A00;
    push_m(1'b0, 32'hA00, '0); push_r(1'b1, '0, 1'b1);
    repeat (9) @(negedge clk);
    chk("tmo_last_wait_ack", dc_ack, 1'b0);
    chk("tmo_last_wait_busy", busy, 1'b1);
    @(negedge clk);
    chk("tmo_resp_ack", dc_ack, 1'b1);
    dc_req = 1'b0;
    repeat (6) @(negedge clk);
    chk("tmo_late_rvalid_busy", busy, 1'b0);
    chk("rsp_data_hold_err", rsp_data, '0);

    // Asynchronous reset in the middle of WAIT
    mem_delay = 5;
    ic_req = 1'b1; ic_addr = 32'h0000_0C00;
    push_m(1'b0, 32'hC00, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0; ic_req = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_mem_addr", mem_addr, '0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_after_busy", busy, 1'b0);

    chk("mq_empty", mq.size(), 0);
    chk("rq_empty", rq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
